// File: rtl/mlp_pkg.sv
// Shared types and elaboration-time helpers for the MLP neuron scheduler.
package mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CLR,
        S_MAC,
        S_STORE,
        S_JUDGE,
        S_DONE
    } state_e;

    localparam logic LAYER_HID = 1'b0;
    localparam logic LAYER_OUT = 1'b1;

    localparam int unsigned PASS_W = 3;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // PE enables for the final pass of a layer: only the PEs holding real neurons.
    function automatic logic [63:0] last_mask(input int unsigned l, input int unsigned n_pe);
        int unsigned rem;
        rem = l % n_pe;
        if (rem == 0) begin
            rem = n_pe;
        end
        return (64'd1 << rem) - 64'd1;
    endfunction

endpackage

// File: rtl/mlp_mod_counter.sv
// Modulo-MAX up-counter with synchronous clear; last flags the terminal count.
module mlp_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] q_o,
    output logic             last_c_o
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = (q_q == TERM) ? '0 : q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign last_c_o = (q_q == TERM);

endmodule

// File: rtl/mlp_neuron_scheduler.sv
// Sequences a shared pool of MAC neurons through the hidden and output layers
// of every test case, with a sample-fetch handshake and a per-test judge strobe.
module mlp_neuron_scheduler
    import mlp_pkg::*;
#(
    parameter int unsigned N_PE    = 10,
    parameter int unsigned N_IN    = 62,
    parameter int unsigned N_HID   = 30,
    parameter int unsigned N_OUT   = 10,
    parameter int unsigned N_TESTS = 750,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned TEST_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              sample_req_o,
    input  logic              sample_ack_i,
    output logic              layer_o,
    output logic [PASS_W-1:0] pass_idx_o,
    output logic [IDX_W-1:0]  in_idx_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic [N_PE-1:0]   pe_ld_en_o,
    output logic              judge_en_o,
    output logic [TEST_W-1:0] test_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned P_HID    = ceil_div(N_HID, N_PE);
    localparam int unsigned P_OUT    = ceil_div(N_OUT, N_PE);
    localparam int unsigned IN_MAX   = max_u(N_IN, N_HID);
    localparam int unsigned PASS_MAX = max_u(P_HID, P_OUT);

    localparam logic [N_PE-1:0]   MASK_HID     = N_PE'(last_mask(N_HID, N_PE));
    localparam logic [N_PE-1:0]   MASK_OUT     = N_PE'(last_mask(N_OUT, N_PE));
    localparam logic [IDX_W-1:0]  FAN_HID_LAST = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]  FAN_OUT_LAST = IDX_W'(N_HID - 1);
    localparam logic [PASS_W-1:0] PASS_HID_LAST = PASS_W'(P_HID - 1);
    localparam logic [PASS_W-1:0] PASS_OUT_LAST = PASS_W'(P_OUT - 1);

    state_e            state_q, state_d;
    logic              sample_req_q, sample_req_d;
    logic              layer_q, layer_d;
    logic              mac_clr_q, mac_clr_d;
    logic              mac_en_q, mac_en_d;
    logic [N_PE-1:0]   pe_ld_en_q, pe_ld_en_d;
    logic              judge_en_q, judge_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_clr, in_inc, pass_clr, pass_inc, test_clr, test_inc;
    logic [IDX_W-1:0]  in_idx;
    logic [PASS_W-1:0] pass_idx;
    logic [TEST_W-1:0] test_idx;
    logic              test_last;
    logic              unused_in_last;
    logic              unused_pass_last;

    // Per-layer fan-in, pass count and last-pass PE mask.
    logic              in_last;
    logic              pass_last;
    logic [N_PE-1:0]   last_pe_mask;

    assign in_last      = (in_idx == ((layer_q == LAYER_OUT) ? FAN_OUT_LAST : FAN_HID_LAST));
    assign pass_last    = (pass_idx == ((layer_q == LAYER_OUT) ? PASS_OUT_LAST : PASS_HID_LAST));
    assign last_pe_mask = (layer_q == LAYER_OUT) ? MASK_OUT : MASK_HID;

    mlp_mod_counter #(.WIDTH(IDX_W), .MAX(IN_MAX)) u_in_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (in_clr),
        .inc_i    (in_inc),
        .q_o      (in_idx),
        .last_c_o (unused_in_last)
    );

    mlp_mod_counter #(.WIDTH(PASS_W), .MAX(PASS_MAX)) u_pass_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (pass_clr),
        .inc_i    (pass_inc),
        .q_o      (pass_idx),
        .last_c_o (unused_pass_last)
    );

    mlp_mod_counter #(.WIDTH(TEST_W), .MAX(N_TESTS)) u_test_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (test_clr),
        .inc_i    (test_inc),
        .q_o      (test_idx),
        .last_c_o (test_last)
    );

    // Next state; strobe outputs are decoded from the state being entered.
    always_comb begin
        state_d      = state_q;
        sample_req_d = 1'b0;
        layer_d      = layer_q;
        pe_ld_en_d   = '0;
        in_clr       = 1'b0;
        in_inc       = 1'b0;
        pass_clr     = 1'b0;
        pass_inc     = 1'b0;
        test_clr     = 1'b0;
        test_inc     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d  = S_FETCH;
                    test_clr = 1'b1;
                end
            end
            S_FETCH: begin
                if (sample_req_q && sample_ack_i) begin
                    state_d  = S_CLR;
                    layer_d  = LAYER_HID;
                    pass_clr = 1'b1;
                    in_clr   = 1'b1;
                end else begin
                    sample_req_d = 1'b1;
                end
            end
            S_CLR: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (in_last) begin
                    state_d    = S_STORE;
                    in_clr     = 1'b1;
                    pe_ld_en_d = pass_last ? last_pe_mask : '1;
                end else begin
                    in_inc = 1'b1;
                end
            end
            S_STORE: begin
                if (!pass_last) begin
                    pass_inc = 1'b1;
                    state_d  = S_CLR;
                end else if (layer_q == LAYER_HID) begin
                    layer_d  = LAYER_OUT;
                    pass_clr = 1'b1;
                    state_d  = S_CLR;
                end else begin
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                if (test_last) begin
                    state_d = S_DONE;
                end else begin
                    test_inc = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mac_clr_d  = (state_d == S_CLR);
        mac_en_d   = (state_d == S_MAC);
        judge_en_d = (state_d == S_JUDGE);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            sample_req_q <= 1'b0;
            layer_q      <= LAYER_HID;
            mac_clr_q    <= 1'b0;
            mac_en_q     <= 1'b0;
            pe_ld_en_q   <= '0;
            judge_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_req_q <= sample_req_d;
            layer_q      <= layer_d;
            mac_clr_q    <= mac_clr_d;
            mac_en_q     <= mac_en_d;
            pe_ld_en_q   <= pe_ld_en_d;
            judge_en_q   <= judge_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sample_req_o = sample_req_q;
    assign layer_o      = layer_q;
    assign pass_idx_o   = pass_idx;
    assign in_idx_o     = in_idx;
    assign mac_clr_o    = mac_clr_q;
    assign mac_en_o     = mac_en_q;
    assign pe_ld_en_o   = pe_ld_en_q;
    assign judge_en_o   = judge_en_q;
    assign test_idx_o   = test_idx;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mlp_neuron_scheduler.sv
// Directed bench: three scheduler instances (short-fan-in full run, single-test
// default, single-test with 8 PEs) checked against hand-computed sequences.
module tb_mlp_neuron_scheduler;
    import mlp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_f = 1'b0;
    logic start_s = 1'b0;
    logic ack_f = 1'b0;
    logic ack_s = 1'b1;

    logic [2:0]       req, lay, mclr, men, jud, bsy, dn;
    logic [2:0][2:0]  pidx;
    logic [2:0][5:0]  iidx;
    logic [2:0][9:0]  tidx;
    logic [9:0]       pe0, pe1;
    logic [7:0]       pe8;
    logic [9:0]       pe_all [3];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mlp_neuron_scheduler #(.N_IN(8)) u_full (
        .clk_i(clk), .rst_i(rst), .start_i(start_f), .sample_req_o(req[0]),
        .sample_ack_i(ack_f), .layer_o(lay[0]), .pass_idx_o(pidx[0]), .in_idx_o(iidx[0]),
        .mac_clr_o(mclr[0]), .mac_en_o(men[0]), .pe_ld_en_o(pe0), .judge_en_o(jud[0]),
        .test_idx_o(tidx[0]), .busy_o(bsy[0]), .done_o(dn[0])
    );

    mlp_neuron_scheduler #(.N_TESTS(1)) u_one (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .sample_req_o(req[1]),
        .sample_ack_i(ack_s), .layer_o(lay[1]), .pass_idx_o(pidx[1]), .in_idx_o(iidx[1]),
        .mac_clr_o(mclr[1]), .mac_en_o(men[1]), .pe_ld_en_o(pe1), .judge_en_o(jud[1]),
        .test_idx_o(tidx[1]), .busy_o(bsy[1]), .done_o(dn[1])
    );

    mlp_neuron_scheduler #(.N_PE(8), .N_TESTS(1)) u_pe8 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .sample_req_o(req[2]),
        .sample_ack_i(ack_s), .layer_o(lay[2]), .pass_idx_o(pidx[2]), .in_idx_o(iidx[2]),
        .mac_clr_o(mclr[2]), .mac_en_o(men[2]), .pe_ld_en_o(pe8), .judge_en_o(jud[2]),
        .test_idx_o(tidx[2]), .busy_o(bsy[2]), .done_o(dn[2])
    );

    always_comb begin
        pe_all[0] = pe0;
        pe_all[1] = pe1;
        pe_all[2] = {2'b00, pe8};
    end

    wire [2:0] in_fetch = {u_pe8.state_q == S_FETCH, u_one.state_q == S_FETCH,
                           u_full.state_q == S_FETCH};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Activity logs per instance, cleared on request between phases.
    logic       clr_logs = 1'b0;
    int         run_cur [3];
    int         n_runs  [3];
    int         runs    [3][8];
    int         n_st    [3];
    logic [9:0] st_pe   [3][8];
    logic [3:0] st_lp   [3][8];
    int         n_jud   [3];
    int         n_req   [3];
    int         viol_mx  = 0;
    int         viol_idx = 0;
    int         viol_req = 0;
    logic [2:0] req_prev = 3'b000;

    always @(negedge clk) begin
        int fan;
        for (int k = 0; k < 3; k++) begin
            if (clr_logs) begin
                run_cur[k] = 0; n_runs[k] = 0; n_st[k] = 0; n_jud[k] = 0; n_req[k] = 0;
            end else begin
                if (men[k]) begin
                    run_cur[k]++;
                end else if (run_cur[k] != 0) begin
                    if (n_runs[k] < 8) runs[k][n_runs[k]] = run_cur[k];
                    n_runs[k]++;
                    run_cur[k] = 0;
                end
                if (pe_all[k] != 10'd0) begin
                    if (n_st[k] < 8) begin
                        st_pe[k][n_st[k]] = pe_all[k];
                        st_lp[k][n_st[k]] = {lay[k], pidx[k]};
                    end
                    n_st[k]++;
                end
                if (jud[k]) n_jud[k]++;
                if (req[k]) n_req[k]++;
            end
            if ((int'(mclr[k]) + int'(men[k]) + int'(pe_all[k] != 10'd0) + int'(jud[k])) > 1)
                viol_mx++;
            fan = lay[k] ? 30 : ((k == 0) ? 8 : 62);
            if (men[k] && int'(iidx[k]) >= fan) viol_idx++;
            if (req[k] && !req_prev[k] && !in_fetch[k]) viol_req++;
            req_prev[k] = req[k];
        end
    end

    task automatic clear_logs();
        clr_logs = 1'b1;
        @(posedge clk); #1;
        clr_logs = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic any_out(input int k);
        return |{req[k], lay[k], pidx[k], iidx[k], mclr[k], men[k], pe_all[k], jud[k],
                 tidx[k], bsy[k], dn[k]};
    endfunction

    int n;
    int d1, d2;
    int exp_run_pe8 [6] = '{62, 62, 62, 62, 30, 30};
    logic [9:0] exp_st_pe8 [6] = '{10'hFF, 10'hFF, 10'hFF, 10'h3F, 10'hFF, 10'h03};
    logic [3:0] exp_lp_pe8 [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9};
    int exp_run_one [4] = '{62, 62, 62, 30};
    logic [3:0] exp_lp_one [4] = '{4'h0, 4'h1, 4'h2, 4'h8};

    initial begin
        // Power-on reset state
        repeat (2) tick();
        for (int k = 0; k < 3; k++) check_eq($sformatf("por_outs%0d", k), 64'(any_out(k)), 64'd0);
        rst = 1'b0;
        clear_logs();

        // Reset asserted mid-MAC, together with start
        ack_f = 1'b1;
        start_f = 1'b1; tick(); start_f = 1'b0;
        n = 0;
        while (!men[0] && n < 40) begin tick(); n++; end
        check_eq("t1_reach_mac", 64'(men[0]), 64'd1);
        tick();
        rst = 1'b1; start_f = 1'b1;
        repeat (3) tick();
        check_eq("t1_outs_in_rst", 64'(any_out(0)), 64'd0);
        check_eq("t1_state_idle", 64'(u_full.state_q), 64'(S_IDLE));
        rst = 1'b0; start_f = 1'b0;
        tick();
        check_eq("t1_outs_after", 64'(any_out(0)), 64'd0);
        check_eq("t1_req_low", 64'(req[0]), 64'd0);
        clear_logs();

        // Single test, default pool and 8-PE pool, immediate ack
        start_s = 1'b1; tick(); start_s = 1'b0;
        n = 0; d1 = -1; d2 = -1;
        while ((d1 < 0 || d2 < 0) && n < 500) begin
            tick(); n++;
            if (dn[1] && d1 < 0) d1 = n;
            if (dn[2] && d2 < 0) d2 = n;
        end
        check_eq("t2_done_cyc", 64'(d1), 64'd227);
        check_eq("t2_nruns", 64'(n_runs[1]), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_run%0d", i), 64'(runs[1][i]), 64'(exp_run_one[i]));
            check_eq($sformatf("t2_st%0d", i), 64'(st_pe[1][i]), 64'h3FF);
            check_eq($sformatf("t2_lp%0d", i), 64'(st_lp[1][i]), 64'(exp_lp_one[i]));
        end
        check_eq("t2_nst", 64'(n_st[1]), 64'd4);
        check_eq("t2_judge", 64'(n_jud[1]), 64'd1);
        check_eq("t2_tidx", 64'(tidx[1]), 64'd0);
        check_eq("t2_busy", 64'(bsy[1]), 64'd0);
        check_eq("t3_done_cyc", 64'(d2), 64'd323);
        check_eq("t3_nruns", 64'(n_runs[2]), 64'd6);
        check_eq("t3_nst", 64'(n_st[2]), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_run%0d", i), 64'(runs[2][i]), 64'(exp_run_pe8[i]));
            check_eq($sformatf("t3_st%0d", i), 64'(st_pe[2][i]), 64'(exp_st_pe8[i]));
            check_eq($sformatf("t3_lp%0d", i), 64'(st_lp[2][i]), 64'(exp_lp_pe8[i]));
        end
        check_eq("t3_judge", 64'(n_jud[2]), 64'd1);

        // Delayed ack, then a spurious ack during MAC
        ack_f = 1'b0;
        clear_logs();
        start_f = 1'b1; tick(); start_f = 1'b0;
        n = 0;
        while (!req[0] && n < 10) begin tick(); n++; end
        check_eq("t4_req_up", 64'(req[0]), 64'd1);
        repeat (4) tick();
        ack_f = 1'b1; tick(); ack_f = 1'b0;
        check_eq("t4_req_drop", 64'(req[0]), 64'd0);
        check_eq("t4_req_cycles", 64'(n_req[0]), 64'd5);
        n = 0;
        while (!men[0] && n < 10) begin tick(); n++; end
        ack_f = 1'b1; repeat (2) tick(); ack_f = 1'b0;
        n = 0;
        while (n_jud[0] < 1 && n < 300) begin tick(); n++; end
        ack_f = 1'b1;
        check_eq("t4_judge", 64'(n_jud[0]), 64'd1);
        check_eq("t4_nruns", 64'(n_runs[0]), 64'd4);
        check_eq("t4_run0", 64'(runs[0][0]), 64'd8);
        check_eq("t4_run2", 64'(runs[0][2]), 64'd8);
        check_eq("t4_run3", 64'(runs[0][3]), 64'd30);
        check_eq("t4_nst", 64'(n_st[0]), 64'd4);
        check_eq("t4_st3", 64'(st_pe[0][3]), 64'h3FF);
        check_eq("t4_req_same", 64'(n_req[0]), 64'd5);
        check_eq("t4_tidx_next", 64'(tidx[0]), 64'd1);

        // Full run; start while busy must not restart
        start_f = 1'b1; tick(); start_f = 1'b0;
        n = 0;
        while (!dn[0] && n < 60000) begin tick(); n++; end
        check_eq("t5_done", 64'(dn[0]), 64'd1);
        check_eq("t5_judges", 64'(n_jud[0]), 64'd750);
        check_eq("t5_tidx_end", 64'(tidx[0]), 64'd749);
        check_eq("t5_busy_end", 64'(bsy[0]), 64'd0);
        repeat (3) tick();
        check_eq("t5_tidx_hold", 64'(tidx[0]), 64'd749);
        start_f = 1'b1; tick(); start_f = 1'b0;
        check_eq("t5_restart_tidx", 64'(tidx[0]), 64'd0);
        check_eq("t5_restart_busy", 64'(bsy[0]), 64'd1);
        check_eq("t5_restart_done", 64'(dn[0]), 64'd0);
        tick();
        check_eq("t5_restart_req", 64'(req[0]), 64'd1);

        // Continuous invariants
        check_eq("inv_mutex", 64'(viol_mx), 64'd0);
        check_eq("inv_in_idx", 64'(viol_idx), 64'd0);
        check_eq("inv_req_rise", 64'(viol_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
